// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the rv32 memory port arbiter.
package mem_port_arbiter_pkg;

    // Arbiter ownership of the shared memory port
    typedef enum logic [1:0] {
        StIdle,
        StData,
        StFetch
    } arb_state_t;

    localparam logic [3:0] SEL_WORD = 4'b1111;
    localparam logic [3:0] SEL_LANE0 = 4'b0001;

    // Store data for a byte access is replicated onto all four lanes
    function automatic logic [31:0] byte_replicate(input logic [7:0] b);
        return {4{b}};
    endfunction

    function automatic logic [31:0] sign_extend_byte(input logic [7:0] b);
        return {{24{b[7]}}, b};
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-bus signal bundle for mem_port_arbiter.
// master: the arbiter's view; slave: the core/memory environment's view.
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 32
);
    // Instruction fetch requester
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [31:0]       if_rdata;
    logic              if_ack;
    // Load/store requester
    logic              d_read;
    logic              d_write;
    logic              d_byte;
    logic [ADDR_W-1:0] d_addr;
    logic [31:0]       d_wdata;
    logic [31:0]       d_rdata;
    logic              d_ack;
    logic              stall;
    // Memory bus
    logic [ADDR_W-1:0] bus_addr;
    logic              bus_ren;
    logic              bus_wen;
    logic [3:0]        bus_sel;
    logic [31:0]       bus_wdata;
    logic [31:0]       bus_rdata;
    logic              bus_done;
    logic              bus_err;

    modport master (
        input  if_req, if_addr, d_read, d_write, d_byte, d_addr, d_wdata, bus_rdata, bus_done,
        output if_rdata, if_ack, d_rdata, d_ack, stall,
        output bus_addr, bus_ren, bus_wen, bus_sel, bus_wdata, bus_err
    );

    modport slave (
        output if_req, if_addr, d_read, d_write, d_byte, d_addr, d_wdata, bus_rdata, bus_done,
        input  if_rdata, if_ack, d_rdata, d_ack, stall,
        input  bus_addr, bus_ren, bus_wen, bus_sel, bus_wdata, bus_err
    );

endinterface

// File: rtl/mem_port_arbiter_byte_lane_unit.sv
// Byte-lane steering: byte enables and store replication on the way out,
// load byte extraction with sign extension on the way back.
module byte_lane_unit
    import mem_port_arbiter_pkg::*;
(
    input  logic [1:0]  lane,
    input  logic        is_byte,
    input  logic [31:0] wdata_in,
    input  logic [31:0] rdata_in,
    output logic [3:0]  sel,
    output logic [31:0] wdata_out,
    output logic [31:0] rdata_out
);

    logic [7:0] rd_byte;

    // Select the addressed read byte
    always_comb begin
        rd_byte = rdata_in[7:0];
        unique case (lane)
            2'd0: rd_byte = rdata_in[7:0];
            2'd1: rd_byte = rdata_in[15:8];
            2'd2: rd_byte = rdata_in[23:16];
            2'd3: rd_byte = rdata_in[31:24];
            default: rd_byte = rdata_in[7:0];
        endcase
    end

    // Word accesses pass straight through; byte accesses use one lane
    always_comb begin
        sel       = SEL_WORD;
        wdata_out = wdata_in;
        rdata_out = rdata_in;
        if (is_byte) begin
            sel       = SEL_LANE0 << lane;
            wdata_out = byte_replicate(wdata_in[7:0]);
            rdata_out = sign_extend_byte(rd_byte);
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the rv32 core's single memory port between instruction fetch and
// load/store. Data has fixed priority; each access is one registered bus
// transaction ending in a one-cycle ack to its owner.
// Optional abort-on-timeout: define ARB_TIMEOUT_EN.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input logic              clk,
    input logic              rst,
    mem_port_arbiter_if.master mp
);

    // A zero timeout would abort every transaction before it could complete
    if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be nonzero");
    end

    arb_state_t        state_q, state_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic              bus_ren_q, bus_ren_d;
    logic              bus_wen_q, bus_wen_d;
    logic [3:0]        bus_sel_q, bus_sel_d;
    logic [31:0]       bus_wdata_q, bus_wdata_d;
    logic [31:0]       if_rdata_q, if_rdata_d;
    logic [31:0]       d_rdata_q, d_rdata_d;
    logic              if_ack_q, if_ack_d;
    logic              d_ack_q, d_ack_d;
    logic              byte_q, byte_d;
    logic [1:0]        lane_q, lane_d;
    logic              err_q, err_d;

    logic              d_req;
    logic              i_req;
    logic              timeout;
    logic [1:0]        lane_mux;
    logic              byte_mux;
    logic [3:0]        lane_sel;
    logic [31:0]       lane_wdata;
    logic [31:0]       lane_rdata;
    logic              unused_if_addr_lo;

    assign unused_if_addr_lo = ^mp.if_addr[1:0];

    // A requester acked this cycle is masked so its held request is not re-granted
    assign d_req = (mp.d_read | mp.d_write) & ~d_ack_q;
    assign i_req = mp.if_req & ~if_ack_q;

    // In IDLE the lane unit encodes the incoming request; otherwise it decodes the return
    assign lane_mux = (state_q == StIdle) ? mp.d_addr[1:0] : lane_q;
    assign byte_mux = (state_q == StIdle) ? mp.d_byte : byte_q;

    byte_lane_unit u_byte_lane (
        .lane      (lane_mux),
        .is_byte   (byte_mux),
        .wdata_in  (mp.d_wdata),
        .rdata_in  (mp.bus_rdata),
        .sel       (lane_sel),
        .wdata_out (lane_wdata),
        .rdata_out (lane_rdata)
    );

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Expires on the TIMEOUT_CYCLES-th strobe cycle without bus_done
    assign timeout = (state_q != StIdle) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // Restart at each grant, count while a transaction is outstanding
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == StIdle) begin
            cnt_d = '0;
        end else if (!mp.bus_done && !timeout) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Timeout counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    // Grant, bus sequencing and completion
    always_comb begin
        state_d     = state_q;
        bus_addr_d  = bus_addr_q;
        bus_ren_d   = bus_ren_q;
        bus_wen_d   = bus_wen_q;
        bus_sel_d   = bus_sel_q;
        bus_wdata_d = bus_wdata_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        if_ack_d    = 1'b0;
        d_ack_d     = 1'b0;
        byte_d      = byte_q;
        lane_d      = lane_q;
        err_d       = err_q;

        case (state_q)
            StIdle: begin
                if (d_req) begin
                    state_d     = StData;
                    bus_addr_d  = {mp.d_addr[ADDR_W-1:2], 2'b00};
                    // Read and write together resolves to a write
                    bus_ren_d   = ~mp.d_write;
                    bus_wen_d   = mp.d_write;
                    bus_sel_d   = lane_sel;
                    bus_wdata_d = lane_wdata;
                    byte_d      = mp.d_byte;
                    lane_d      = mp.d_addr[1:0];
                end else if (i_req) begin
                    state_d     = StFetch;
                    bus_addr_d  = {mp.if_addr[ADDR_W-1:2], 2'b00};
                    bus_ren_d   = 1'b1;
                    bus_wen_d   = 1'b0;
                    bus_sel_d   = SEL_WORD;
                    byte_d      = 1'b0;
                    lane_d      = 2'd0;
                end
            end
            StData, StFetch: begin
                if (mp.bus_done || timeout) begin
                    state_d   = StIdle;
                    bus_ren_d = 1'b0;
                    bus_wen_d = 1'b0;
                    if (state_q == StData) begin
                        d_ack_d = 1'b1;
                        if (!mp.bus_done) begin
                            d_rdata_d = '0;
                        end else if (!bus_wen_q) begin
                            d_rdata_d = lane_rdata;
                        end
                    end else begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = mp.bus_done ? mp.bus_rdata : 32'h0;
                    end
                    if (!mp.bus_done) begin
                        err_d = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            bus_addr_q  <= '0;
            bus_ren_q   <= 1'b0;
            bus_wen_q   <= 1'b0;
            bus_sel_q   <= '0;
            bus_wdata_q <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            if_ack_q    <= 1'b0;
            d_ack_q     <= 1'b0;
            byte_q      <= 1'b0;
            lane_q      <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            bus_addr_q  <= bus_addr_d;
            bus_ren_q   <= bus_ren_d;
            bus_wen_q   <= bus_wen_d;
            bus_sel_q   <= bus_sel_d;
            bus_wdata_q <= bus_wdata_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            if_ack_q    <= if_ack_d;
            d_ack_q     <= d_ack_d;
            byte_q      <= byte_d;
            lane_q      <= lane_d;
            err_q       <= err_d;
        end
    end

    assign mp.bus_addr  = bus_addr_q;
    assign mp.bus_ren   = bus_ren_q;
    assign mp.bus_wen   = bus_wen_q;
    assign mp.bus_sel   = bus_sel_q;
    assign mp.bus_wdata = bus_wdata_q;
    assign mp.if_rdata  = if_rdata_q;
    assign mp.d_rdata   = d_rdata_q;
    assign mp.if_ack    = if_ack_q;
    assign mp.d_ack     = d_ack_q;
    assign mp.bus_err   = err_q;
    assign mp.stall     = (state_q != StIdle) | d_req | i_req;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter.
// The abort scenario runs only when ARB_TIMEOUT_EN is defined.
module tb_mem_port_arbiter;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    mem_port_arbiter_if #(.ADDR_W(32)) mp ();

    mem_port_arbiter #(
        .ADDR_W         (32),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .mp  (mp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge so registered outputs have settled
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        mp.if_req    = 1'b0;
        mp.if_addr   = '0;
        mp.d_read    = 1'b0;
        mp.d_write   = 1'b0;
        mp.d_byte    = 1'b0;
        mp.d_addr    = '0;
        mp.d_wdata   = '0;
        mp.bus_rdata = '0;
        mp.bus_done  = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        idle_inputs();
        tick();
        tick();

        // Reset state
        check_eq("rst_bus_ren", mp.bus_ren, 0);
        check_eq("rst_bus_wen", mp.bus_wen, 0);
        check_eq("rst_bus_sel", mp.bus_sel, 0);
        check_eq("rst_bus_addr", mp.bus_addr, 0);
        check_eq("rst_bus_wdata", mp.bus_wdata, 0);
        check_eq("rst_acks", {mp.if_ack, mp.d_ack}, 0);
        check_eq("rst_rdata", mp.if_rdata | mp.d_rdata, 0);
        check_eq("rst_bus_err", mp.bus_err, 0);
        check_eq("rst_stall", mp.stall, 0);
        rst = 1'b0;
        tick();

        // IF word read at 0x100, bus_done three cycles after the strobe rises
        mp.if_req  = 1'b1;
        mp.if_addr = 32'h100;
        settle();
        check_eq("if_req_stall", mp.stall, 1);
        tick();
        check_eq("if_ren", mp.bus_ren, 1);
        check_eq("if_wen", mp.bus_wen, 0);
        check_eq("if_addr", mp.bus_addr, 32'h100);
        check_eq("if_sel", mp.bus_sel, 4'hF);
        tick();
        tick();
        check_eq("if_wait_stall", mp.stall, 1);
        check_eq("if_wait_ack", mp.if_ack, 0);
        check_eq("if_wait_ren", mp.bus_ren, 1);
        tick();
        mp.bus_done  = 1'b1;
        mp.bus_rdata = 32'h0000_0013;
        tick();
        check_eq("if_ack", mp.if_ack, 1);
        check_eq("if_rdata", mp.if_rdata, 32'h13);
        check_eq("if_ack_ren", mp.bus_ren, 0);
        check_eq("if_ack_stall", mp.stall, 0);
        mp.bus_done = 1'b0;
        mp.if_req   = 1'b0;
        tick();
        check_eq("if_ack_pulse", mp.if_ack, 0);
        check_eq("if_rdata_hold", mp.if_rdata, 32'h13);

        // IF and byte load raised together: data wins, fetch follows the turnaround
        mp.if_req  = 1'b1;
        mp.if_addr = 32'h104;
        mp.d_read  = 1'b1;
        mp.d_byte  = 1'b1;
        mp.d_addr  = 32'h2003;
        tick();
        check_eq("lb_ren", mp.bus_ren, 1);
        check_eq("lb_addr", mp.bus_addr, 32'h2000);
        check_eq("lb_sel", mp.bus_sel, 4'h8);
        mp.bus_done  = 1'b1;
        mp.bus_rdata = 32'h80FF_FFFF;
        tick();
        check_eq("lb_d_ack", mp.d_ack, 1);
        check_eq("lb_if_ack", mp.if_ack, 0);
        check_eq("lb_rdata", mp.d_rdata, 32'hFFFF_FF80);
        check_eq("lb_stall_if_waiting", mp.stall, 1);
        mp.d_read   = 1'b0;
        mp.d_byte   = 1'b0;
        mp.bus_done = 1'b0;
        tick();
        check_eq("lb_then_if_ren", mp.bus_ren, 1);
        check_eq("lb_then_if_addr", mp.bus_addr, 32'h104);
        check_eq("lb_then_if_sel", mp.bus_sel, 4'hF);
        check_eq("lb_d_ack_pulse", mp.d_ack, 0);
        mp.bus_done  = 1'b1;
        mp.bus_rdata = 32'hDEAD_BEEF;
        tick();
        check_eq("lb_then_if_ack", mp.if_ack, 1);
        check_eq("lb_then_if_rdata", mp.if_rdata, 32'hDEAD_BEEF);
        check_eq("lb_d_rdata_hold", mp.d_rdata, 32'hFFFF_FF80);
        mp.if_req   = 1'b0;
        mp.bus_done = 1'b0;
        tick();

        // Byte store to 0x41
        mp.d_write = 1'b1;
        mp.d_byte  = 1'b1;
        mp.d_addr  = 32'h41;
        mp.d_wdata = 32'h1234_5678;
        tick();
        check_eq("sb_wen", mp.bus_wen, 1);
        check_eq("sb_ren", mp.bus_ren, 0);
        check_eq("sb_sel", mp.bus_sel, 4'h2);
        check_eq("sb_wdata", mp.bus_wdata, 32'h7878_7878);
        check_eq("sb_addr", mp.bus_addr, 32'h40);
        tick();
        check_eq("sb_stable_sel", mp.bus_sel, 4'h2);
        check_eq("sb_no_early_ack", mp.d_ack, 0);
        mp.bus_done = 1'b1;
        tick();
        check_eq("sb_d_ack", mp.d_ack, 1);
        check_eq("sb_wen_drop", mp.bus_wen, 0);
        mp.d_write  = 1'b0;
        mp.d_byte   = 1'b0;
        mp.bus_done = 1'b0;
        tick();

        // Read+write together on a misaligned word: a word write at the aligned address
        mp.d_read  = 1'b1;
        mp.d_write = 1'b1;
        mp.d_addr  = 32'h87;
        mp.d_wdata = 32'hCAFE_F00D;
        tick();
        check_eq("sw_wen", mp.bus_wen, 1);
        check_eq("sw_ren", mp.bus_ren, 0);
        check_eq("sw_sel", mp.bus_sel, 4'hF);
        check_eq("sw_addr", mp.bus_addr, 32'h84);
        check_eq("sw_wdata", mp.bus_wdata, 32'hCAFE_F00D);
        mp.bus_done = 1'b1;
        tick();
        check_eq("sw_d_ack", mp.d_ack, 1);
        mp.d_read   = 1'b0;
        mp.d_write  = 1'b0;
        mp.bus_done = 1'b0;
        tick();

        // Fetch held through its ack with bus_done stuck high
        mp.if_req   = 1'b1;
        mp.if_addr  = 32'h200;
        mp.bus_done = 1'b1;
        mp.bus_rdata = 32'h1111_2222;
        tick();
        check_eq("held_ren", mp.bus_ren, 1);
        tick();
        check_eq("held_ack", mp.if_ack, 1);
        check_eq("held_ack_stall", mp.stall, 0);
        tick();
        check_eq("held_no_dup_ren", mp.bus_ren, 0);
        check_eq("held_ack_once", mp.if_ack, 0);
        check_eq("held_rereq_stall", mp.stall, 1);
        mp.if_req   = 1'b0;
        mp.bus_done = 1'b0;
        tick();
        check_eq("held_idle_ren", mp.bus_ren, 0);
        check_eq("held_idle_stall", mp.stall, 0);

        // Reset in the middle of a fetch, then a stray bus_done
        mp.if_req  = 1'b1;
        mp.if_addr = 32'h300;
        tick();
        check_eq("mid_rst_pre_ren", mp.bus_ren, 1);
        rst = 1'b1;
        tick();
        check_eq("mid_rst_ren", mp.bus_ren, 0);
        check_eq("mid_rst_addr", mp.bus_addr, 0);
        check_eq("mid_rst_sel", mp.bus_sel, 0);
        check_eq("mid_rst_rdata", mp.if_rdata | mp.d_rdata, 0);
        check_eq("mid_rst_ack", {mp.if_ack, mp.d_ack}, 0);
        rst         = 1'b0;
        mp.if_req   = 1'b0;
        mp.bus_done = 1'b1;
        tick();
        check_eq("late_done_ack", mp.if_ack, 0);
        check_eq("late_done_ren", mp.bus_ren, 0);
        check_eq("late_done_stall", mp.stall, 0);
        mp.bus_done = 1'b0;
        tick();

`ifdef ARB_TIMEOUT_EN
        // No bus_done: abort after four strobe cycles
        mp.d_read = 1'b1;
        mp.d_addr = 32'h500;
        tick();
        for (int i = 0; i < 3; i++) begin
            check_eq("to_ren_held", mp.bus_ren, 1);
            tick();
        end
        check_eq("to_ren_last", mp.bus_ren, 1);
        check_eq("to_no_err_yet", mp.bus_err, 0);
        tick();
        check_eq("to_d_ack", mp.d_ack, 1);
        check_eq("to_d_rdata", mp.d_rdata, 0);
        check_eq("to_err", mp.bus_err, 1);
        check_eq("to_ren_drop", mp.bus_ren, 0);
        mp.d_read = 1'b0;
        tick();
        tick();
        check_eq("to_err_sticky", mp.bus_err, 1);
        rst = 1'b1;
        tick();
        check_eq("to_err_rst", mp.bus_err, 0);
        rst = 1'b0;
        tick();
`else
        check_eq("no_timeout_err", mp.bus_err, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single memory port of the rv32 core between instruction fetch (IF) and load/store data access (D).
- D requests are driven from the decoder's read_mem/write_mem/load_byte/store_byte controls.
- Sequences each access as a registered bus transaction, generates byte lanes, extracts load bytes, returns per-requester ack pulses, and stalls the pipeline while any access is outstanding.

Parameters:
- ADDR_W, 32, address width of requesters and bus
- TIMEOUT_CYCLES, 64, cycles to wait for bus_done before aborting (only used with ARB_TIMEOUT_EN)

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- if_req  in  1  fetch request, held until if_ack
- if_addr  in  ADDR_W  fetch address
- if_rdata  out  32  fetched word, valid with if_ack
- if_ack  out  1  one-cycle fetch completion pulse
- d_read  in  1  load request (read_mem)
- d_write  in  1  store request (write_mem)
- d_byte  in  1  byte access (load_byte/store_byte)
- d_addr  in  ADDR_W  data address
- d_wdata  in  32  store data
- d_rdata  out  32  load data, valid with d_ack
- d_ack  out  1  one-cycle data completion pulse
- stall  out  1  pipeline hold
- bus_addr  out  ADDR_W  word-aligned address
- bus_ren  out  1  read strobe
- bus_wen  out  1  write strobe
- bus_sel  out  4  byte enables
- bus_wdata  out  32  write data
- bus_rdata  in  32  read data, valid with bus_done
- bus_done  in  1  transaction complete
- bus_err  out  1  sticky timeout flag (ARB_TIMEOUT_EN only, else tied 0)

Clock and reset: one clock, clk. Reset rst is synchronous and active-high.

Behaviour:
- Reset: state IDLE. Every output is 0: if_ack, d_ack, bus_ren, bus_wen, bus_sel, bus_addr, bus_wdata, if_rdata, d_rdata, bus_err.
- Reset mid-transaction:
  - Strobes drop at the next edge.
  - No ack is issued.
  - A late bus_done is ignored.
- States:
  - IDLE: no transaction; evaluates requests.
  - DATA: a D transaction is issued.
  - FETCH: an IF transaction is issued.
- Grant (evaluated in IDLE):
  - D has fixed priority over IF, because D belongs to the older instruction.
  - d_write together with d_read: treated as a write.
  - The requester acked in the current cycle is masked for that cycle (turnaround), so a still-high request is not re-granted.
- Latency:
  - Request seen in IDLE at cycle N → bus strobe registered high from N+1.
  - bus_done sampled at cycle M ≥ N+1 → strobes low, ack pulse and rdata registered at M+1, state IDLE at M+1.
  - Minimum request-to-ack latency is 2 cycles.
- bus_done in IDLE is ignored.
- Bus outputs are stable for the whole transaction.
  - bus_addr = addr with bits [1:0] forced to 0.
- Word access:
  - bus_sel = 4'b1111.
  - bus_wdata = d_wdata.
  - Misaligned low address bits are dropped; no fault is raised.
- Byte access, lane k = d_addr[1:0]:
  - bus_sel = 1<<k.
  - Store: bus_wdata = four copies of d_wdata[7:0].
  - Load: d_rdata = bus_rdata byte k, sign-extended to 32 bits.
- IF accesses are always word reads.
- stall = (state != IDLE) OR (IDLE and any unmasked request present).
  - stall is combinational and low in the ack cycle unless the other requester is waiting.
- Requester outputs: if_rdata and d_rdata hold their last value between acks. if_ack and d_ack are never high in the same cycle.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- Defined:
  - A counter restarts at each grant and counts while in DATA or FETCH.
  - When it reaches TIMEOUT_CYCLES without bus_done, the transaction aborts: strobes drop, the owner gets its ack with rdata 0, bus_err sets, and the state returns to IDLE.
  - bus_err clears only on rst.
- Undefined: no counter; the arbiter waits indefinitely; bus_err is constant 0.

Decomposition:
- Shared package:
  - arb_state_t enum (IDLE, DATA, FETCH).
  - Byte-lane constants (SEL_WORD = 4'b1111).
- One sub-module, byte_lane_unit: combinational sel/wdata generation and load byte extraction with sign extension, from addr[1:0] and byte flag.

Test Plan:
- IF read at 0x100, bus_done 3 cycles after strobe, bus_rdata 0x00000013 → bus_addr 0x100, bus_sel F, if_ack one cycle later with if_rdata 0x13, stall high throughout.
- IF and d_read at 0x2003 raised together → DATA first: bus_addr 0x2000, bus_sel 8, bus_rdata 0x80FFFFFF gives d_rdata 0xFFFFFF80. The IF grant follows the turnaround cycle.
- Byte store, d_addr 0x41, d_wdata 0x12345678 → bus_wen, bus_sel 2, bus_wdata 0x78787878, d_ack after bus_done.
- Request held high through ack with back-to-back bus_done → no duplicate transaction in the ack cycle; stall low there.
- rst asserted while in FETCH, then bus_done pulse → no if_ack, all outputs 0, state IDLE.
- ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4, no bus_done → abort after 4 cycles, d_ack with d_rdata 0, bus_err stays 1 until rst.
